mem_port_arbiter: RTL

Shares one single-ported unified memory between the fetch stage and the memory stage of the 5-stage pipeline. Data-stage accesses have priority, and a starvation counter bounds fetch delay. The block produces the fetch and memory stall requests consumed by the hazard unit, and discards fetch responses killed by a branch flush. Only one memory transaction is outstanding at any time.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/starve_counter.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory-port arbiter.
//   mem_arb_state_t : arbiter FSM states
//   mem_req_t       : one latched memory request {we, addr, wdata, be}
package mem_arb_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_BE_W   = MEM_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_IF  = 3'd1,
    WAIT_IF = 3'd2,
    REQ_DM  = 3'd3,
    WAIT_DM = 3'd4
  } mem_arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_BE_W-1:0]   be;
  } mem_req_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating counter used to bound how long a low-priority requester waits.
//   i_clk    : clock
//   i_rst    : asynchronous active-low reset
//   i_inc    : count one more lost arbitration (ignored once saturated)
//   i_clr    : clear to zero (wins over i_inc)
//   o_at_max : counter has reached MAX
module starve_counter #(
  parameter int unsigned MAX = 4,
  localparam int unsigned W = $clog2(MAX + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign o_at_max = (cnt_q == W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && !o_at_max) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch stage (IF) and the
// memory stage (DM). DM has priority; after STARVE_MAX consecutive DM grants
// with fetch waiting, fetch wins the next arbitration. One transaction is
// outstanding at a time. Fetch responses killed by i_if_flush are dropped.
//   i_clk, i_rst          : clock, asynchronous active-low reset
//   i_if_req/addr/flush   : fetch request, address, kill pulse
//   o_if_rdata/valid      : fetch response (one-cycle pulse)
//   i_dm_req/we/addr/wdata/be : data-stage request
//   o_dm_rdata/valid      : data-stage completion (one-cycle pulse)
//   o_mem_*               : registered memory request bus
//   i_mem_gnt/rvalid/rdata: memory handshake and response
//   o_stall_if/o_stall_dm : stall requests to the hazard unit
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  input  logic                i_if_flush,
  output logic [DATA_W-1:0]   o_if_rdata,
  output logic                o_if_valid,
  input  logic                i_dm_req,
  input  logic                i_dm_we,
  input  logic [ADDR_W-1:0]   i_dm_addr,
  input  logic [DATA_W-1:0]   i_dm_wdata,
  input  logic [DATA_W/8-1:0] i_dm_be,
  output logic [DATA_W-1:0]   o_dm_rdata,
  output logic                o_dm_valid,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_be,
  input  logic                i_mem_gnt,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_stall_if,
  output logic                o_stall_dm
);

  mem_arb_state_t state_q, state_d;
  mem_req_t       req_q, req_d;
  logic           mem_req_q, mem_req_d;
  logic           drop_q, drop_d;
  logic           starve_inc, starve_clr, starve_at_max;

  starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_inc    (starve_inc),
    .i_clr    (starve_clr),
    .o_at_max (starve_at_max)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    mem_req_d  = mem_req_q;
    drop_d     = drop_q;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (!i_if_req) begin
          starve_clr = 1'b1;
        end
        // DM wins unless fetch is waiting and has already lost STARVE_MAX times.
        if (i_dm_req && (!starve_at_max || !i_if_req)) begin
          state_d     = REQ_DM;
          mem_req_d   = 1'b1;
          req_d.we    = i_dm_we;
          req_d.addr  = MEM_ADDR_W'(i_dm_addr);
          req_d.wdata = MEM_DATA_W'(i_dm_wdata);
          req_d.be    = MEM_BE_W'(i_dm_be);
          starve_inc  = i_if_req;
        end else if (i_if_req && !i_if_flush) begin
          state_d     = REQ_IF;
          mem_req_d   = 1'b1;
          req_d.we    = 1'b0;
          req_d.addr  = MEM_ADDR_W'(i_if_addr);
          req_d.wdata = '0;
          req_d.be    = '1;
          starve_clr  = 1'b1;
        end
      end
      REQ_IF: begin
        // A flush only marks the response for dropping; the bus request stays
        // up so the handshake is never aborted.
        if (i_if_flush) begin
          drop_d = 1'b1;
        end
        if (i_mem_gnt) begin
          state_d   = WAIT_IF;
          mem_req_d = 1'b0;
        end
      end
      WAIT_IF: begin
        if (i_if_flush) begin
          drop_d = 1'b1;
        end
        if (i_mem_rvalid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end
      end
      REQ_DM: begin
        if (i_mem_gnt) begin
          state_d   = WAIT_DM;
          mem_req_d = 1'b0;
        end
      end
      WAIT_DM: begin
        if (i_mem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        drop_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      mem_req_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      mem_req_q <= mem_req_d;
      drop_q    <= drop_d;
    end
  end

  // A flush in the same cycle as the response also suppresses it.
  assign o_if_valid  = (state_q == WAIT_IF) && i_mem_rvalid && !drop_q && !i_if_flush;
  assign o_dm_valid  = (state_q == WAIT_DM) && i_mem_rvalid;
  assign o_if_rdata  = o_if_valid ? i_mem_rdata : '0;
  assign o_dm_rdata  = o_dm_valid ? i_mem_rdata : '0;

  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = req_q.we;
  assign o_mem_addr  = ADDR_W'(req_q.addr);
  assign o_mem_wdata = DATA_W'(req_q.wdata);
  assign o_mem_be    = (DATA_W/8)'(req_q.be);

  assign o_stall_if  = i_if_req && !o_if_valid;
  assign o_stall_dm  = i_dm_req && !o_dm_valid;

endmodule
